argument_encoder: RTL and testbench

//  Bit packer upstream of argument_decoder: takes variable-length fields (1..WIDTH_IN bits each) and packs them LSB-first, with no gaps, into WIDTH_OUT-bit words.

---
 rtl/argument_encoder_pkg.sv | 17 +
 rtl/argument_encoder_if.sv | 30 +++
 rtl/argument_encoder.sv | 96 +++++++++
 tb/tb_argument_encoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argument_encoder_pkg.sv
// Shared helpers and default widths for the argument encoder bit packer.
package argument_encoder_pkg;

  localparam int DEFAULT_WIDTH_IN  = 64;
  localparam int DEFAULT_WIDTH_OUT = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/argument_encoder_if.sv
// Field-in / packed-word-out bundle between a field producer, the encoder and the decoder FIFO.
interface argument_encoder_if
  import argument_encoder_pkg::*;
#(
  parameter int WIDTH_IN  = DEFAULT_WIDTH_IN,
  parameter int WIDTH_OUT = DEFAULT_WIDTH_OUT
);
  localparam int LEN_WIDTH = log2(WIDTH_IN) + 1;

  logic                 push;
  logic [WIDTH_IN-1:0]  d;
  logic [LEN_WIDTH-1:0] len;
  logic                 flush;
  logic                 stall;
  logic                 full;
  logic [WIDTH_OUT-1:0] q;
  logic                 q_push;
  logic                 idle;

  modport master (
    output push, d, len, flush, stall,
    input  full, q, q_push, idle
  );

  modport slave (
    input  push, d, len, flush, stall,
    output full, q, q_push, idle
  );

endinterface

// File: rtl/argument_encoder.sv
// Packs variable-length fields LSB-first, gap-free, into fixed-width words; flush zero-pads the tail.
module argument_encoder
  import argument_encoder_pkg::*;
#(
  parameter int WIDTH_IN  = DEFAULT_WIDTH_IN,
  parameter int WIDTH_OUT = DEFAULT_WIDTH_OUT
) (
  input  logic               clk,
  input  logic               rst,
  argument_encoder_if.slave  bus
);

  localparam int BUFFER_WIDTH      = WIDTH_OUT + WIDTH_IN;
  localparam int LOG2_BUFFER_WIDTH = log2(BUFFER_WIDTH) + 1;
  localparam logic [WIDTH_IN:0] ONE_WIDE = {{WIDTH_IN{1'b0}}, 1'b1};

  typedef logic [LOG2_BUFFER_WIDTH-1:0] count_t;

  logic [BUFFER_WIDTH-1:0] bit_buf_reg, bit_buf_next;
  count_t                  count_reg, count_next;
  logic                    flush_pend_reg, flush_pend_next;
  logic [WIDTH_OUT-1:0]    q_reg, q_next;
  logic                    q_push_reg, q_push_next;

  logic                    full;
  logic                    accept;
  logic                    emit;
  logic [WIDTH_IN:0]       len_mask_wide;
  logic [WIDTH_IN-1:0]     d_masked;
  logic [WIDTH_OUT-1:0]    word_mask;
  logic [BUFFER_WIDTH-1:0] buf_shifted;
  count_t                  count_after_emit;

  // Only bits below count are valid in a partial (flushed) word.
  generate
    for (genvar gi = 0; gi < WIDTH_OUT; gi++) begin : g_word_mask
      assign word_mask[gi] = (count_reg > count_t'(gi));
    end
  endgenerate

  always_comb begin
    full          = flush_pend_reg | (count_reg > count_t'(BUFFER_WIDTH - WIDTH_IN));
    accept        = bus.push & ~full;
    emit          = ~bus.stall & ((count_reg >= count_t'(WIDTH_OUT)) |
                                  (flush_pend_reg & (count_reg != '0)));
    len_mask_wide = (ONE_WIDE << bus.len) - ONE_WIDE;
    d_masked      = bus.d & len_mask_wide[WIDTH_IN-1:0];
  end

  // Emit works on pre-accept contents; the accepted field lands at the post-emit fill level.
  always_comb begin
    buf_shifted      = bit_buf_reg;
    count_after_emit = count_reg;
    q_next           = q_reg;
    q_push_next      = 1'b0;
    if (emit) begin
      buf_shifted      = bit_buf_reg >> WIDTH_OUT;
      count_after_emit = (count_reg >= count_t'(WIDTH_OUT)) ?
                         count_reg - count_t'(WIDTH_OUT) : '0;
      q_next           = bit_buf_reg[WIDTH_OUT-1:0] & word_mask;
      q_push_next      = 1'b1;
    end

    bit_buf_next = buf_shifted;
    count_next   = count_after_emit;
    if (accept) begin
      bit_buf_next = buf_shifted |
                     ({{(BUFFER_WIDTH - WIDTH_IN){1'b0}}, d_masked} << count_after_emit);
      count_next   = count_after_emit + count_t'(bus.len);
    end

    flush_pend_next = (bus.flush | flush_pend_reg) & (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_buf_reg    <= '0;
      count_reg      <= '0;
      flush_pend_reg <= 1'b0;
      q_reg          <= '0;
      q_push_reg     <= 1'b0;
    end else begin
      bit_buf_reg    <= bit_buf_next;
      count_reg      <= count_next;
      flush_pend_reg <= flush_pend_next;
      q_reg          <= q_next;
      q_push_reg     <= q_push_next;
    end
  end

  assign bus.full   = full;
  assign bus.q      = q_reg;
  assign bus.q_push = q_push_reg;
  assign bus.idle   = (count_reg == '0) & ~flush_pend_reg;

endmodule

// File: tb/tb_argument_encoder.sv
// Bench for argument_encoder: directed scenarios plus randomized fields against a bit-stream model.
module tb_argument_encoder;

  localparam int WI = 64;
  localparam int WO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  argument_encoder_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

  argument_encoder #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WO-1:0] got_q[$];
  logic [WO-1:0] exp_q[$];
  bit            model_bits[$];
  bit            stall_rand = 1'b0;

  // Capture every emitted word shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (bus.q_push === 1'b1) got_q.push_back(bus.q);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the output is the concatenated field bit stream cut into 64-bit words.
  task automatic model_form_word();
    logic [WO-1:0] w;
    w = '0;
    for (int i = 0; i < WO; i++) begin
      if (model_bits.size() > 0) w[i] = model_bits.pop_front();
    end
    exp_q.push_back(w);
  endtask

  task automatic model_push(input logic [WI-1:0] d, input int len);
    for (int i = 0; i < len; i++) model_bits.push_back(d[i]);
    while (model_bits.size() >= WO) model_form_word();
  endtask

  task automatic model_flush();
    if (model_bits.size() > 0) model_form_word();
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    model_bits.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    if (stall_rand) bus.stall = ($urandom_range(0, 2) == 0);
  endtask

  task automatic push_field(input logic [WI-1:0] d, input int len);
    int waited;
    waited = 0;
    while (bus.full === 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.full !== 1'b0) begin
      errors++;
      $display("FAIL push_wait: full=%b, required 0 within 300 cycles", bus.full);
    end else begin
      bus.push = 1'b1;
      bus.d    = d;
      bus.len  = 7'(len);
      model_push(d, len);
      tick();
      bus.push = 1'b0;
    end
  endtask

  task automatic flush_field();
    bus.flush = 1'b1;
    model_flush();
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 400) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.push  = 1'b1;
    bus.d     = 64'h0000_0000_0000_00AB;
    bus.len   = 7'd8;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.q_push !== 1'b0) begin errors++; $display("FAIL reset_q_push: got %b, required 0", bus.q_push); end
    checks++;
    if (bus.q !== 64'h0) begin errors++; $display("FAIL reset_q: got %h, required 0", bus.q); end
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", bus.full); end
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", bus.idle); end
    rst      = 1'b1;
    bus.push = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_no_accept: idle=%b, required 1", bus.idle); end
    $display("test_reset done");
  endtask

  task automatic test_bytes();
    clear_all();
    for (int i = 1; i <= 8; i++) push_field(64'(i), 8);
    checks++;
    if (bus.q_push !== 1'b0) begin errors++; $display("FAIL bytes_early: q_push=%b, required 0", bus.q_push); end
    tick();
    checks++;
    if (bus.q_push !== 1'b1 || bus.q !== 64'h0807060504030201) begin
      errors++;
      $display("FAIL bytes_word: q_push=%b q=%h, required 1 / 0807060504030201", bus.q_push, bus.q);
    end
    tick();
    checks++;
    if (bus.idle !== 1'b1 || bus.q_push !== 1'b0) begin
      errors++;
      $display("FAIL bytes_idle: idle=%b q_push=%b, required 1 / 0", bus.idle, bus.q_push);
    end
    $display("test_bytes done: q=%h", got_q.size() > 0 ? got_q[0] : 64'h0);
  endtask

  task automatic test_split_flush();
    clear_all();
    push_field(64'h0000_00AA_BBCC_DDEE, 40);
    push_field(64'h0000_0011_2233_4455, 40);
    wait_words(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 64'h334455AABBCCDDEE) begin
      errors++;
      $display("FAIL split_word: count=%0d first=%h, required 1 / 334455AABBCCDDEE",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0);
    end
    flush_field();
    wait_words(2);
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 64'h0000000000001122) begin
      errors++;
      $display("FAIL split_flush: count=%0d second=%h, required 2 / 0000000000001122",
               got_q.size(), got_q.size() > 1 ? got_q[1] : 64'h0);
    end
    tick();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL split_idle: got %b, required 1", bus.idle); end
    $display("test_split_flush done: words=%0d", got_q.size());
  endtask

  task automatic test_mask();
    clear_all();
    for (int i = 0; i < 16; i++) push_field(64'hFFFFFFFFFFFFFFF5, 4);
    wait_words(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 64'h5555555555555555) begin
      errors++;
      $display("FAIL mask_word: count=%0d q=%h, required 1 / 5555555555555555",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0);
    end
    $display("test_mask done");
  endtask

  task automatic test_stall();
    logic [WI-1:0] a, b;
    clear_all();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bus.stall = 1'b1;
    push_field(a, 64);
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL stall_full64: got %b, required 0", bus.full); end
    push_field(b, 64);
    checks++;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL stall_full128: got %b, required 1", bus.full); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.q_push !== 1'b0) begin errors++; $display("FAIL stall_hold: q_push=%b at cycle %0d, required 0", bus.q_push, i); end
      tick();
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.q_push !== 1'b1 || bus.q !== a) begin
      errors++;
      $display("FAIL stall_first: q_push=%b q=%h, required 1 / %h", bus.q_push, bus.q, a);
    end
    tick();
    checks++;
    if (bus.q_push !== 1'b1 || bus.q !== b) begin
      errors++;
      $display("FAIL stall_second: q_push=%b q=%h, required 1 / %h", bus.q_push, bus.q, b);
    end
    tick();
    checks++;
    if (bus.idle !== 1'b1 || bus.q_push !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: idle=%b q_push=%b, required 1 / 0", bus.idle, bus.q_push);
    end
    $display("test_stall done");
  endtask

  task automatic test_reset_mid_and_flush_push();
    logic [WI-1:0] d;
    logic [WO-1:0] want;
    clear_all();
    push_field({$urandom, $urandom}, 24);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    clear_all();
    checks++;
    if (bus.idle !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: idle=%b full=%b, required 1 / 0", bus.idle, bus.full);
    end
    flush_field();
    repeat (4) tick();
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL empty_flush: words=%0d, required 0", got_q.size()); end
    d         = {$urandom, $urandom};
    want      = {48'h0, d[15:0]};
    bus.push  = 1'b1;
    bus.d     = d;
    bus.len   = 7'd16;
    bus.flush = 1'b1;
    tick();
    bus.push  = 1'b0;
    bus.flush = 1'b0;
    wait_words(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      errors++;
      $display("FAIL flush_push: count=%0d q=%h, required 1 / %h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0, want);
    end
    tick();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL flush_push_idle: got %b, required 1", bus.idle); end
    $display("test_reset_mid_and_flush_push done");
  endtask

  task automatic test_random();
    int len;
    clear_all();
    stall_rand = 1'b1;
    for (int n = 0; n < 160; n++) begin
      len = $urandom_range(1, WI);
      push_field({$urandom, $urandom}, len);
      if ($urandom_range(0, 19) == 0) flush_field();
    end
    flush_field();
    stall_rand = 1'b0;
    bus.stall  = 1'b0;
    wait_words(exp_q.size());
    repeat (3) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL random_idle: got %b, required 1", bus.idle); end
    $display("test_random done: %0d words", exp_q.size());
  endtask

  initial begin
    test_reset();
    test_bytes();
    test_split_flush();
    test_mask();
    test_stall();
    test_reset_mid_and_flush_push();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
